// File: rtl/jc2_decoder.sv
// Johnson-code monitor: samples jc2's bus, decodes position/direction, flags illegal or skipped codes.
// Optional JC2_DECODER_SYNC_EN puts a 2-flop synchronizer ahead of the sample register.
module jc2_decoder #(
   parameter int WIDTH        = 4,
   parameter int STALL_CYCLES = 4,
   parameter int PW           = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] q,
   input  logic             clr,
   output logic [PW-1:0]    pos,
   output logic             dir_left,
   output logic             dir_right,
   output logic             stopped,
   output logic             code_err,
   output logic             skip_err,
   output logic [7:0]       err_cnt,
   output logic [15:0]      net_steps
);

   localparam int NSTATE = 2*WIDTH;
   localparam int SCW    = $clog2(STALL_CYCLES+1);

   logic [WIDTH-1:0] s;
   logic [SCW-1:0]   stallCnt;
   logic             havePrev;
   logic             legal;
   logic             isErr;
   logic [PW-1:0]    pDec;
   int               ones, trans, pInt, dInt;

`ifdef JC2_DECODER_SYNC_EN
   logic [WIDTH-1:0] syncA, syncB;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syncA <= '0;
         syncB <= '0;
         s     <= '0;
      end else begin
         syncA <= q;
         syncB <= syncA;
         s     <= syncB;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s <= '0;
      else        s <= q;
   end
`endif

   // pos doubles as the previous-position register: it only changes on legal samples,
   // which is exactly when prev is refreshed.
   always_comb begin
      ones  = 0;
      trans = 0;
      for (int i = 0; i < WIDTH; i++) ones += int'(s[i]);
      for (int i = 0; i < WIDTH-1; i++) trans += int'(s[i] != s[i+1]);
      legal = (trans <= 1);
      pInt  = s[0] ? ones : (NSTATE - ones) % NSTATE;
      pDec  = PW'(pInt);
      dInt  = pInt - int'(pos);
      if (dInt < 0) dInt += NSTATE;
      isErr = !legal || (havePrev && dInt != 0 && dInt != 1 && dInt != NSTATE-1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos       <= '0;
         dir_left  <= 1'b0;
         dir_right <= 1'b0;
         stopped   <= 1'b0;
         code_err  <= 1'b0;
         skip_err  <= 1'b0;
         err_cnt   <= '0;
         net_steps <= '0;
         stallCnt  <= '0;
         havePrev  <= 1'b0;
      end else begin
         code_err <= 1'b0;
         skip_err <= 1'b0;
         if (!legal) begin
            code_err <= 1'b1;
            stallCnt <= '0;
         end else if (!havePrev) begin
            pos      <= pDec;
            havePrev <= 1'b1;
            stallCnt <= '0;
         end else begin
            pos <= pDec;
            if (dInt == 0) begin
               if (int'(stallCnt) < STALL_CYCLES) begin
                  stallCnt <= stallCnt + SCW'(1);
                  stopped  <= (int'(stallCnt) + 1 >= STALL_CYCLES);
               end
            end else begin
               stallCnt <= '0;
               stopped  <= 1'b0;
               if (dInt == 1) begin
                  dir_left  <= 1'b1;
                  dir_right <= 1'b0;
                  net_steps <= net_steps + 16'd1;
               end else if (dInt == NSTATE-1) begin
                  dir_left  <= 1'b0;
                  dir_right <= 1'b1;
                  net_steps <= net_steps - 16'd1;
               end else begin
                  skip_err <= 1'b1;
               end
            end
         end
         // clr wins over any counter update made above
         if (clr) begin
            err_cnt   <= '0;
            net_steps <= '0;
            stallCnt  <= '0;
            stopped   <= 1'b0;
         end else if (isErr && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_jc2_decoder.sv
// Directed bench for jc2_decoder (WIDTH=4, STALL_CYCLES=4, no synchronizer).
// Outputs after each tick reflect the q driven on the tick before.
module tb_jc2_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  q;
   logic        clr;
   logic [2:0]  pos;
   logic        dir_left, dir_right, stopped, code_err, skip_err;
   logic [7:0]  err_cnt;
   logic [15:0] net_steps;

   int vecs = 0;
   int miscompares = 0;

   jc2_decoder #(.WIDTH(4), .STALL_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .q(q), .clr(clr), .pos(pos),
      .dir_left(dir_left), .dir_right(dir_right), .stopped(stopped),
      .code_err(code_err), .skip_err(skip_err), .err_cnt(err_cnt),
      .net_steps(net_steps)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vecs++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input logic [3:0] qv);
      q = qv;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] seq1 [0:8];

   initial begin
      seq1 = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
               4'b1110, 4'b1100, 4'b1000, 4'b0000};
      rst_n = 1'b0; q = 4'b0000; clr = 1'b0;
      #12;
      chk("rst_pos", 16'(pos), 16'd0);
      chk("rst_net", net_steps, 16'd0);
      chk("rst_err", 16'(err_cnt), 16'd0);
      chk("rst_flags", 16'({dir_left, dir_right, stopped, code_err, skip_err}), 16'd0);
      rst_n = 1'b1;

      // full left lap with 7->0 wrap
      tick(seq1[0]);
      for (int i = 1; i <= 8; i++) begin
         tick(seq1[i]);
         chk($sformatf("lap_pos%0d", i-1), 16'(pos), 16'(i-1));
      end
      tick(seq1[8]);
      chk("lap_wrap_pos", 16'(pos), 16'd0);
      chk("lap_net", net_steps, 16'd8);
      chk("lap_dir", 16'({dir_left, dir_right}), 16'b10);
      chk("lap_err", 16'(err_cnt), 16'd0);

      clr = 1'b1; tick(4'b0000); clr = 1'b0;
      chk("clr_net", net_steps, 16'd0);

      // right steps with 0->7 wrap
      tick(4'b1000);
      tick(4'b1100);
      chk("right_pos7", 16'(pos), 16'd7);
      chk("right_dir", 16'({dir_left, dir_right}), 16'b01);
      tick(4'b1100);
      chk("right_pos6", 16'(pos), 16'd6);
      chk("right_net", net_steps, 16'hFFFE);

      // stall detection
      tick(4'b1000);
      tick(4'b1000);
      chk("stall_pos", 16'(pos), 16'd7);
      chk("stall_dirl", 16'(dir_left), 16'd1);
      tick(4'b1000); tick(4'b1000); tick(4'b1000);
      chk("stall_not_yet", 16'(stopped), 16'd0);
      tick(4'b1000);
      chk("stall_stopped", 16'(stopped), 16'd1);
      tick(4'b0000);
      chk("stall_hold", 16'(stopped), 16'd1);
      tick(4'b0000);
      chk("stall_release", 16'(stopped), 16'd0);
      chk("stall_rel_pos", 16'(pos), 16'd0);

      // illegal code between 0011 and 0111
      tick(4'b0001); tick(4'b0011); tick(4'b0101); tick(4'b0111);
      chk("ill_code_err", 16'(code_err), 16'd1);
      chk("ill_pos_hold", 16'(pos), 16'd2);
      chk("ill_err_cnt", 16'(err_cnt), 16'd1);
      tick(4'b0111);
      chk("ill_code_clr", 16'(code_err), 16'd0);
      chk("ill_pos3", 16'(pos), 16'd3);
      chk("ill_net", net_steps, 16'd3);

      // skipped step 0001 -> 0111
      tick(4'b0011); tick(4'b0001); tick(4'b0111);
      chk("pre_skip_pos", 16'(pos), 16'd1);
      tick(4'b0111);
      chk("skip_err", 16'(skip_err), 16'd1);
      chk("skip_pos", 16'(pos), 16'd3);
      chk("skip_err_cnt", 16'(err_cnt), 16'd2);
      chk("skip_net", net_steps, 16'd1);
      chk("skip_dir_hold", 16'({dir_left, dir_right}), 16'b01);
      tick(4'b0111);
      chk("skip_pulse_end", 16'(skip_err), 16'd0);

      // saturate err_cnt, then clr with a concurrent error
      for (int k = 0; k < 260; k++) tick(k[0] ? 4'b1010 : 4'b0101);
      chk("sat_err_cnt", 16'(err_cnt), 16'd255);
      chk("sat_pos_hold", 16'(pos), 16'd3);
      clr = 1'b1; tick(4'b0101); clr = 1'b0;
      chk("clr_err_cnt", 16'(err_cnt), 16'd0);
      chk("clr_net2", net_steps, 16'd0);
      chk("clr_code_pulse", 16'(code_err), 16'd1);
      tick(4'b0111);
      chk("post_clr_cnt", 16'(err_cnt), 16'd1);

      // asynchronous reset mid-cycle
      #3 rst_n = 1'b0;
      #1;
      chk("arst_pos", 16'(pos), 16'd0);
      chk("arst_err", 16'(err_cnt), 16'd0);
      chk("arst_flags", 16'({dir_left, dir_right, stopped, code_err, skip_err}), 16'd0);
      #2 rst_n = 1'b1;
      q = 4'b0000;
      tick(4'b0001);
      chk("seed_pos", 16'(pos), 16'd0);
      chk("seed_net", net_steps, 16'd0);
      tick(4'b0011);
      chk("after_seed_pos", 16'(pos), 16'd1);
      chk("after_seed_net", net_steps, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule
